// File: rtl/nv_nvdla_csb2apb_pkg.sv
// Shared types and constants for the CSB-to-APB bridge.
package nv_nvdla_csb2apb_pkg;

    localparam int CSB_ADDR_W = 16;
    localparam int DATA_W     = 32;
    localparam int APB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic [CSB_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     wdat;
        logic                  write;
        logic                  nposted;
    } csb_req_t;

    // CSB addresses are word addresses; APB wants bytes under a fixed window.
    function automatic logic [APB_ADDR_W-1:0] csb2apb_addr(input logic [13:0]           base_hi,
                                                           input logic [CSB_ADDR_W-1:0] addr);
        return {base_hi, addr, 2'b00};
    endfunction

endpackage

// File: rtl/nv_nvdla_csb2apb_if.sv
// CSB target + APB master bundle. "slave" is the bridge's view, "master" the environment's.
// NVDLA_CSB2APB_WR_COMPLETE_EN adds the write-completion return signal.
interface nv_nvdla_csb2apb_if;
    import nv_nvdla_csb2apb_pkg::*;

    logic                  csb2nvdla_valid;
    logic                  csb2nvdla_ready;
    logic [CSB_ADDR_W-1:0] csb2nvdla_addr;
    logic [DATA_W-1:0]     csb2nvdla_wdat;
    logic                  csb2nvdla_write;
    logic                  csb2nvdla_nposted;
    logic                  nvdla2csb_valid;
    logic [DATA_W-1:0]     nvdla2csb_data;
`ifdef NVDLA_CSB2APB_WR_COMPLETE_EN
    logic                  nvdla2csb_wr_complete;
`endif
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_ADDR_W-1:0] paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;

`ifdef NVDLA_CSB2APB_WR_COMPLETE_EN
    modport slave (
        input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
        output csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );
    modport master (
        output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
        input  csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
`else
    modport slave (
        input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
        output csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );
    modport master (
        output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
        input  csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
`endif

endinterface

// File: rtl/nv_nvdla_csb2apb.sv
// CSB-to-APB bridge: one outstanding CSB request replayed as an APB3 transfer.
// Optional NVDLA_CSB2APB_WR_COMPLETE_EN returns completions for non-posted writes.
module nv_nvdla_csb2apb
    import nv_nvdla_csb2apb_pkg::*;
#(
    parameter logic [31:0] APB_BASE = 32'h0000_0000
) (
    input  logic                pclk,
    input  logic                prstn,
    nv_nvdla_csb2apb_if.slave   bus
);

    state_e            state;
    state_e            state_nxt;
    csb_req_t          req;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              accept;
    logic              done;

    assign accept = bus.csb2nvdla_valid & bus.csb2nvdla_ready;
    assign done   = (state == ACCESS) & bus.pready;

    always_ff @(posedge pclk) begin
        if (!prstn) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (bus.pready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!prstn) begin
            req <= '0;
        end else if (accept) begin
            req.addr    <= bus.csb2nvdla_addr;
            req.wdat    <= bus.csb2nvdla_wdat;
            req.write   <= bus.csb2nvdla_write;
            req.nposted <= bus.csb2nvdla_nposted;
        end
    end

    // Reset clears rsp_valid so a response caught mid-reset never returns.
    always_ff @(posedge pclk) begin
        if (!prstn) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= done & ~req.write;
            if (done & ~req.write) rsp_data <= bus.prdata;
        end
    end

`ifdef NVDLA_CSB2APB_WR_COMPLETE_EN
    logic wr_cpl;

    always_ff @(posedge pclk) begin
        if (!prstn) wr_cpl <= 1'b0;
        else        wr_cpl <= done & req.write & req.nposted;
    end

    assign bus.nvdla2csb_wr_complete = wr_cpl;
`else
    logic unused_nposted;
    assign unused_nposted = req.nposted;
`endif

    assign bus.csb2nvdla_ready = prstn & (state == IDLE);
    assign bus.psel            = (state != IDLE);
    assign bus.penable         = (state == ACCESS);
    assign bus.pwrite          = req.write;
    assign bus.paddr           = csb2apb_addr(APB_BASE[31:18], req.addr);
    assign bus.pwdata          = req.wdat;
    assign bus.nvdla2csb_valid = rsp_valid;
    assign bus.nvdla2csb_data  = rsp_data;

endmodule

// File: tb/tb_nv_nvdla_csb2apb.sv
// Directed bench for nv_nvdla_csb2apb: vector table plus hand-built corner sequences.
module tb_nv_nvdla_csb2apb;
    import nv_nvdla_csb2apb_pkg::*;

`ifdef NVDLA_CSB2APB_WR_COMPLETE_EN
    localparam bit WC_EN = 1'b1;
`else
    localparam bit WC_EN = 1'b0;
`endif

    logic pclk  = 1'b0;
    logic prstn = 1'b0;
    always #5 pclk = ~pclk;

    nv_nvdla_csb2apb_if bus ();
    nv_nvdla_csb2apb_if bus2 ();

    nv_nvdla_csb2apb u_dut (
        .pclk  (pclk),
        .prstn (prstn),
        .bus   (bus.slave)
    );

    nv_nvdla_csb2apb #(.APB_BASE(32'h4000_0000)) u_dut2 (
        .pclk  (pclk),
        .prstn (prstn),
        .bus   (bus2.slave)
    );

    int npass  = 0;
    int ntotal = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic get_wc();
`ifdef NVDLA_CSB2APB_WR_COMPLETE_EN
        return bus.nvdla2csb_wr_complete;
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        string       tag;
        logic        write;
        logic        nposted;
        logic [15:0] addr;
        logic [31:0] wdat;
        logic [31:0] prdata;
        int          waits;
        logic [31:0] exp_paddr;
        logic        exp_rv;
        logic        exp_wc;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        @(negedge pclk);
        check({v.tag, " ready_idle"}, bus.csb2nvdla_ready, 1'b1);
        bus.csb2nvdla_valid   = 1'b1;
        bus.csb2nvdla_write   = v.write;
        bus.csb2nvdla_nposted = v.nposted;
        bus.csb2nvdla_addr    = v.addr;
        bus.csb2nvdla_wdat    = v.wdat;
        // cycle 1: SETUP; scramble CSB inputs to prove the request is registered
        @(negedge pclk);
        bus.csb2nvdla_valid = 1'b0;
        bus.csb2nvdla_addr  = 16'hBEEF;
        bus.csb2nvdla_wdat  = 32'hFFFF_0000;
        bus.csb2nvdla_write = ~v.write;
        check({v.tag, " setup_sel_en"}, {30'h0, bus.psel, bus.penable}, 32'h2);
        check({v.tag, " paddr"}, bus.paddr, v.exp_paddr);
        check({v.tag, " pwrite"}, bus.pwrite, v.write);
        check({v.tag, " ready_busy"}, bus.csb2nvdla_ready, 1'b0);
        bus.pready = 1'b1;          // must be ignored in SETUP
        bus.prdata = 32'hDEAD_BEEF;
        for (int k = 0; k <= v.waits; k++) begin
            @(negedge pclk);
            check({v.tag, " access_sel_en"}, {30'h0, bus.psel, bus.penable}, 32'h3);
            check({v.tag, " pwdata"}, bus.pwdata, v.wdat);
            bus.pready = (k == v.waits);
            bus.prdata = (k == v.waits) ? v.prdata : 32'hDEAD_BEEF;
        end
        @(negedge pclk);
        bus.pready = 1'b0;
        check({v.tag, " rsp_valid"}, bus.nvdla2csb_valid, v.exp_rv);
        check({v.tag, " wr_complete"}, get_wc(), v.exp_wc);
        check({v.tag, " ready_back"}, bus.csb2nvdla_ready, 1'b1);
        check({v.tag, " psel_idle"}, bus.psel, 1'b0);
        if (v.exp_rv) last_rd = v.prdata;
        check({v.tag, " rsp_data"}, bus.nvdla2csb_data, last_rd);
        @(negedge pclk);
        check({v.tag, " pulse_end"}, {30'h0, bus.nvdla2csb_valid, get_wc()}, 32'h0);
        check({v.tag, " paddr_hold"}, bus.paddr, v.exp_paddr);
    endtask

    initial begin
        bus.csb2nvdla_valid = 1'b0;  bus.csb2nvdla_addr = '0;  bus.csb2nvdla_wdat = '0;
        bus.csb2nvdla_write = 1'b0;  bus.csb2nvdla_nposted = 1'b0;
        bus.prdata = '0;  bus.pready = 1'b0;
        bus2.csb2nvdla_valid = 1'b0; bus2.csb2nvdla_addr = '0; bus2.csb2nvdla_wdat = '0;
        bus2.csb2nvdla_write = 1'b0; bus2.csb2nvdla_nposted = 1'b0;
        bus2.prdata = '0; bus2.pready = 1'b0;

        vecs[0] = '{"rd_cafe",   1'b0, 1'b0, 16'h0010, 32'h0000_0001, 32'hCAFE_F00D, 0, 32'h0000_0040, 1'b1, 1'b0};
        vecs[1] = '{"wr_posted", 1'b1, 1'b0, 16'h0003, 32'h1234_5678, 32'h7777_7777, 3, 32'h0000_000C, 1'b0, 1'b0};
        vecs[2] = '{"wr_np",     1'b1, 1'b1, 16'h1234, 32'hA5A5_A5A5, 32'h6666_6666, 1, 32'h0000_48D0, 1'b0, WC_EN};
        vecs[3] = '{"rd_top",    1'b0, 1'b1, 16'hFFFF, 32'h0000_0002, 32'h0BAD_F00D, 2, 32'h0003_FFFC, 1'b1, 1'b0};
        vecs[4] = '{"rd_zero",   1'b0, 1'b0, 16'h0000, 32'h0000_0003, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1'b0};

        // reset state
        repeat (2) @(negedge pclk);
        check("rst ready", bus.csb2nvdla_ready, 1'b0);
        check("rst sel_en_wr", {29'h0, bus.psel, bus.penable, bus.pwrite}, 32'h0);
        check("rst paddr", bus.paddr, 32'h0);
        check("rst pwdata", bus.pwdata, 32'h0);
        check("rst rsp", {31'h0, bus.nvdla2csb_valid}, 32'h0);
        check("rst data", bus.nvdla2csb_data, 32'h0);
        check("rst wc", get_wc(), 1'b0);
        check("rst paddr base", bus2.paddr, 32'h4000_0000);
        prstn = 1'b1;
        @(negedge pclk);
        check("rst release ready", bus.csb2nvdla_ready, 1'b1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // back-to-back: read then write with valid held high
        @(negedge pclk);
        bus.csb2nvdla_valid = 1'b1; bus.csb2nvdla_write = 1'b0; bus.csb2nvdla_nposted = 1'b0;
        bus.csb2nvdla_addr  = 16'h0020; bus.csb2nvdla_wdat = 32'h0;
        @(negedge pclk);
        bus.csb2nvdla_write = 1'b1; bus.csb2nvdla_addr = 16'h0021; bus.csb2nvdla_wdat = 32'h0000_55AA;
        check("b2b c1 ready", bus.csb2nvdla_ready, 1'b0);
        check("b2b c1 paddr", bus.paddr, 32'h0000_0080);
        check("b2b c1 pwrite", bus.pwrite, 1'b0);
        @(negedge pclk);
        check("b2b c2 ready", bus.csb2nvdla_ready, 1'b0);
        check("b2b c2 penable", bus.penable, 1'b1);
        bus.pready = 1'b1; bus.prdata = 32'h1111_2222;
        @(negedge pclk);
        bus.pready = 1'b0; bus.prdata = 32'hDEAD_BEEF;
        check("b2b c3 rsp_valid", bus.nvdla2csb_valid, 1'b1);
        check("b2b c3 data", bus.nvdla2csb_data, 32'h1111_2222);
        check("b2b c3 ready", bus.csb2nvdla_ready, 1'b1);
        @(negedge pclk);
        bus.csb2nvdla_valid = 1'b0;
        check("b2b c4 sel_en", {30'h0, bus.psel, bus.penable}, 32'h2);
        check("b2b c4 pwrite", bus.pwrite, 1'b1);
        check("b2b c4 paddr", bus.paddr, 32'h0000_0084);
        check("b2b c4 pwdata", bus.pwdata, 32'h0000_55AA);
        check("b2b c4 rsp_valid", bus.nvdla2csb_valid, 1'b0);
        @(negedge pclk);
        bus.pready = 1'b1;
        @(negedge pclk);
        bus.pready = 1'b0;
        check("b2b c6 rsp_valid", bus.nvdla2csb_valid, 1'b0);
        check("b2b c6 data hold", bus.nvdla2csb_data, 32'h1111_2222);
        check("b2b c6 ready", bus.csb2nvdla_ready, 1'b1);
        check("b2b c6 psel", bus.psel, 1'b0);

        // reset during ACCESS with pready low
        @(negedge pclk);
        bus.csb2nvdla_valid = 1'b1; bus.csb2nvdla_write = 1'b0; bus.csb2nvdla_addr = 16'h0005;
        @(negedge pclk);
        bus.csb2nvdla_valid = 1'b0;
        @(negedge pclk);
        check("mid_rst access", {30'h0, bus.psel, bus.penable}, 32'h3);
        prstn = 1'b0; bus.prdata = 32'h9999_9999;
        @(negedge pclk);
        check("mid_rst sel_en", {30'h0, bus.psel, bus.penable}, 32'h0);
        check("mid_rst ready", bus.csb2nvdla_ready, 1'b0);
        check("mid_rst rsp", bus.nvdla2csb_valid, 1'b0);
        prstn = 1'b1; bus.pready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            check("post_rst quiet", {29'h0, bus.nvdla2csb_valid, bus.psel, bus.csb2nvdla_ready}, 32'h1);
        end
        bus.pready = 1'b0;

        // high APB_BASE window
        @(negedge pclk);
        bus2.csb2nvdla_valid = 1'b1; bus2.csb2nvdla_write = 1'b0; bus2.csb2nvdla_addr = 16'hFFFF;
        @(negedge pclk);
        bus2.csb2nvdla_valid = 1'b0;
        check("base paddr", bus2.paddr, 32'h4003_FFFC);
        bus2.pready = 1'b1; bus2.prdata = 32'h0000_ABCD;
        @(negedge pclk);
        @(negedge pclk);
        bus2.pready = 1'b0;
        check("base rsp_valid", bus2.nvdla2csb_valid, 1'b1);
        check("base data", bus2.nvdla2csb_data, 32'h0000_ABCD);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
